// File: rtl/find_extents.sv
// Star extent finder: scans rows [mostTop, mostBottom] outward from
// the seed column and reports leftmost/rightmost bright columns.
module find_extents #(
  parameter int XW        = 3,
  parameter int YW        = 3,
  parameter int AW        = 6,
  parameter int CW        = 3,
  parameter int WIDTH     = 6,
  parameter int HEIGHT    = 6,
  parameter int THRESHOLD = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [YW-1:0] mostTop,
  input  logic [YW-1:0] mostBottom,
  input  logic [XW-1:0] midPix,
  output logic [AW-1:0] mem_addr,
  input  logic [CW-1:0] mem_q,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [XW-1:0] mostLeft,
  output logic [XW-1:0] mostRight
);

  typedef enum logic [2:0] {
    IDLE,
    ROW_START,
    ADDR,
    CMP,
    NEXT_ROW,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MID,
    RIGHT,
    LEFT
  } phase_t;

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [AW-1:0] WA   = AW'(WIDTH);
  localparam logic [31:0]   W32  = 32'(WIDTH);
  localparam logic [31:0]   H32  = 32'(HEIGHT);
  localparam logic [31:0]   T32  = 32'(THRESHOLD);

  state_t        state;
  state_t        stateNext;
  phase_t        phase;
  phase_t        phaseNext;
  logic [XW-1:0] x;
  logic [XW-1:0] xNext;
  logic [XW-1:0] midReg;
  logic [YW-1:0] y;
  logic [YW-1:0] yNext;
  logic [YW-1:0] bottomReg;
  logic          accept;
  logic          badParams;
  logic          bright;
  logic          update;
  logic          toLeft;

  assign badParams = (mostTop > mostBottom)
                  || (32'(mostBottom) >= H32)
                  || (32'(midPix) >= W32);
  assign bright = 32'(mem_q) > T32;
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

  // Next-state, scan position and extent-update decisions.
  always_comb begin
    stateNext = state;
    phaseNext = phase;
    xNext     = x;
    yNext     = y;
    accept    = 1'b0;
    update    = 1'b0;
    toLeft    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          yNext     = mostTop;
          stateNext = badParams ? DONE : ROW_START;
        end
      end
      ROW_START: begin
        xNext     = midReg;
        phaseNext = MID;
        stateNext = ADDR;
      end
      ADDR: begin
        stateNext = CMP;
      end
      CMP: begin
        unique case (phase)
          MID: begin
            if (!bright) begin
              stateNext = NEXT_ROW;
            end else begin
              update = 1'b1;
              if (x == XMAX) begin
                toLeft = 1'b1;
              end else begin
                xNext     = x + XW'(1);
                phaseNext = RIGHT;
                stateNext = ADDR;
              end
            end
          end
          RIGHT: begin
            if (bright) begin
              update = 1'b1;
              if (x == XMAX) begin
                toLeft = 1'b1;
              end else begin
                xNext     = x + XW'(1);
                stateNext = ADDR;
              end
            end else begin
              toLeft = 1'b1;
            end
          end
          LEFT: begin
            if (bright) begin
              update = 1'b1;
              if (x == '0) begin
                stateNext = NEXT_ROW;
              end else begin
                xNext     = x - XW'(1);
                stateNext = ADDR;
              end
            end else begin
              stateNext = NEXT_ROW;
            end
          end
          default: begin
            stateNext = NEXT_ROW;
          end
        endcase
        if (toLeft) begin
          if (midReg == '0) begin
            stateNext = NEXT_ROW;
          end else begin
            xNext     = midReg - XW'(1);
            phaseNext = LEFT;
            stateNext = ADDR;
          end
        end
      end
      NEXT_ROW: begin
        if (y == bottomReg) begin
          stateNext = DONE;
        end else begin
          yNext     = y + YW'(1);
          stateNext = ROW_START;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, scan position, address register and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= MID;
      x         <= '0;
      y         <= '0;
      midReg    <= '0;
      bottomReg <= '0;
      mem_addr  <= '0;
      found     <= 1'b0;
      err       <= 1'b0;
      mostLeft  <= '0;
      mostRight <= '0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
      x     <= xNext;
      y     <= yNext;
      if (accept) begin
        midReg    <= midPix;
        bottomReg <= mostBottom;
        mostLeft  <= XMAX;
        mostRight <= '0;
        found     <= 1'b0;
        err       <= badParams;
      end
      if (update) begin
        found <= 1'b1;
        if (x < mostLeft) mostLeft <= x;
        if (x > mostRight) mostRight <= x;
      end
      if (stateNext == ADDR) begin
        mem_addr <= AW'(yNext) * WA + AW'(xNext);
      end
    end
  end

endmodule

// File: tb/tb_find_extents.sv
// Scoreboard bench for find_extents: stimulus pushes expectations,
// a negedge monitor pops and compares on busy/done activity.
module tb_find_extents;

  localparam int XW = 3;
  localparam int YW = 3;
  localparam int AW = 6;
  localparam int CW = 3;
  localparam int W  = 6;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [YW-1:0] mostTop;
  logic [YW-1:0] mostBottom;
  logic [XW-1:0] midPix;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_q = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic          err;
  logic [XW-1:0] mostLeft;
  logic [XW-1:0] mostRight;

  logic [CW-1:0] img [W*H];

  typedef struct {
    int lat;
    int fnd;
    int er;
    int ml;
    int mr;
    int lastAddr;
    int abortJob;
  } exp_t;

  typedef struct {
    int off;
    int addr;
  } ae_t;

  exp_t expQ[$];
  ae_t  addrQ[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   lastAddr = 0;
  bit   inJob    = 0;
  int   off      = 0;

  find_extents #(
    .XW(XW), .YW(YW), .AW(AW), .CW(CW),
    .WIDTH(W), .HEIGHT(H), .THRESHOLD(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mostTop(mostTop),
    .mostBottom(mostBottom),
    .midPix(midPix),
    .mem_addr(mem_addr),
    .mem_q(mem_q),
    .busy(busy),
    .done(done),
    .found(found),
    .err(err),
    .mostLeft(mostLeft),
    .mostRight(mostRight)
  );

  always #5 clk = ~clk;

  // Synchronous read-only image RAM
  always @(posedge clk) begin
    if (int'(mem_addr) < W * H) mem_q <= img[int'(mem_addr)];
    else mem_q <= '0;
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic bit br(int xx, int yy);
    return img[yy * W + xx] > 0;
  endfunction

  task automatic clearImg();
    for (int i = 0; i < W * H; i++) img[i] = '0;
  endtask

  task automatic setPix(int xx, int yy);
    img[yy * W + xx] = CW'(5);
  endtask

  // Reference model: per row, the bright run containing the seed column,
  // the read order (mid, right run, left run plus dark terminators),
  // and the resulting cycle cost.
  task automatic issue(input int top, input int bot, input int mid,
                       input bit abortJob);
    exp_t e;
    ae_t  a;
    int   o;
    int   l;
    int   r;
    int   xs[$];
    e.abortJob = abortJob;
    e.er  = (top > bot || bot >= H || mid >= W) ? 1 : 0;
    e.fnd = 0;
    e.ml  = W - 1;
    e.mr  = 0;
    if (e.er != 0) begin
      e.lat = 1;
    end else begin
      o = 1;
      for (int yy = top; yy <= bot; yy++) begin
        xs.delete();
        xs.push_back(mid);
        if (br(mid, yy)) begin
          r = mid;
          while (r < W - 1 && br(r + 1, yy)) r++;
          for (int xx = mid + 1; xx <= r; xx++) xs.push_back(xx);
          if (r < W - 1) xs.push_back(r + 1);
          l = mid;
          while (l > 0 && br(l - 1, yy)) l--;
          for (int xx = mid - 1; xx >= l; xx--) xs.push_back(xx);
          if (l > 0) xs.push_back(l - 1);
          e.fnd = 1;
          if (l < e.ml) e.ml = l;
          if (r > e.mr) e.mr = r;
        end
        foreach (xs[k]) begin
          a.off  = o + 1 + 2 * k;
          a.addr = yy * W + xs[k];
          if (!abortJob) addrQ.push_back(a);
          lastAddr = a.addr;
        end
        o += 2 * xs.size() + 2;
      end
      e.lat = o;
    end
    e.lastAddr = lastAddr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    mostTop    = YW'(top);
    mostBottom = YW'(bot);
    midPix     = XW'(mid);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((inJob || expQ.size() != 0) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL timeout inJob=%0d pending=%0d", inJob, expQ.size());
      expQ.delete();
      addrQ.delete();
      inJob = 0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetVals();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_mostLeft", int'(mostLeft), 0);
    chk("rst_mostRight", int'(mostRight), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
  endtask

  // Monitor: pops an expectation when a job becomes visible, checks
  // addresses at their read cycles and all results at done.
  always @(negedge clk) begin
    if (reset) begin
      if (inJob) begin
        chk("abort_expected", cur.abortJob, 1);
        inJob = 0;
      end
    end else begin
      if (!inJob && (busy || done)) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_job busy=%0d done=%0d", busy, done);
        end else begin
          cur   = expQ.pop_front();
          inJob = 1;
          off   = 1;
        end
      end else if (inJob) begin
        off++;
      end
      if (inJob) begin
        if (addrQ.size() > 0 && addrQ[0].off == off) begin
          chk("mem_addr", int'(mem_addr), addrQ[0].addr);
          void'(addrQ.pop_front());
        end
        if (done) begin
          chk("latency", off, cur.lat);
          chk("found", int'(found), cur.fnd);
          chk("err", int'(err), cur.er);
          chk("mostLeft", int'(mostLeft), cur.ml);
          chk("mostRight", int'(mostRight), cur.mr);
          chk("addr_final", int'(mem_addr), cur.lastAddr);
          chk("busy_at_done", int'(busy), 0);
          chk("reads_left", addrQ.size(), 0);
          if (cur.abortJob != 0) begin
            checks++;
            failures++;
            $display("FAIL abort_done done pulse seen for aborted job");
          end
          addrQ.delete();
          inJob = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int top;
    int bot;
    int mid;
    int p;
    reset      = 1'b1;
    start      = 1'b0;
    mostTop    = '0;
    mostBottom = '0;
    midPix     = '0;
    clearImg();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetVals();

    // Single bright pixel
    clearImg();
    setPix(3, 2);
    issue(2, 2, 3, 0);
    waitIdle();

    // Diamond
    clearImg();
    setPix(2, 1);
    setPix(1, 2);
    setPix(2, 2);
    setPix(3, 2);
    setPix(2, 3);
    issue(1, 3, 2, 0);
    waitIdle();

    // Full bright row, both image edges reached
    clearImg();
    for (int xx = 0; xx < W; xx++) setPix(xx, 4);
    issue(4, 4, 2, 0);
    waitIdle();

    // Dark seed in first row, run at right edge in second
    clearImg();
    setPix(4, 1);
    setPix(5, 1);
    issue(0, 1, 4, 0);
    waitIdle();

    // Bad parameters, then a valid start clears err
    issue(3, 1, 2, 0);
    waitIdle();
    issue(6, 7, 0, 0);
    waitIdle();
    issue(0, 1, 4, 0);
    waitIdle();

    // Start during busy and during DONE are ignored
    clearImg();
    for (int xx = 0; xx < W; xx++) setPix(xx, 4);
    issue(4, 4, 2, 0);
    @(posedge clk);
    #1;
    mostTop    = '0;
    mostBottom = YW'(5);
    midPix     = '0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();
    repeat (4) @(posedge clk);
    #2;
    chk("ignored_busy", int'(busy), 0);
    chk("ignored_mostLeft", int'(mostLeft), 0);
    chk("ignored_mostRight", int'(mostRight), W - 1);

    // Reset while scanning right
    issue(4, 4, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    lastAddr = 0;
    checkResetVals();
    expQ.delete();
    addrQ.delete();

    // Randomized images and parameters
    for (int t = 0; t < 40; t++) begin
      p = $urandom_range(20, 80);
      for (int i = 0; i < W * H; i++) begin
        if ($urandom_range(0, 99) < p) img[i] = CW'($urandom_range(1, 7));
        else img[i] = '0;
      end
      if ($urandom_range(0, 5) == 0) begin
        top = $urandom_range(0, 7);
        bot = $urandom_range(0, 7);
        mid = $urandom_range(0, 7);
      end else begin
        top = $urandom_range(0, H - 1);
        bot = $urandom_range(top, H - 1);
        mid = $urandom_range(0, W - 1);
      end
      issue(top, bot, mid, 0);
      waitIdle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/find_extents.md
# find_extents

Parametrised successor to the single-direction right-edge finder. Given the star's top row, bottom row and seed column from the top/bottom finder, it scans every row in [mostTop, mostBottom] outward from the seed column in both directions. It reports the leftmost and rightmost bright pixel columns, with a start/done handshake. It reads the read-only image RAM through one synchronous read port and sits between the top/bottom finder and the centroid/size logic.

## Interface
- XW, 3: column coordinate width
- YW, 3: row coordinate width
- AW, 6: RAM address width
- CW, 3: pixel value width
- WIDTH, 6: image width in pixels; address = y*WIDTH + x
- HEIGHT, 6: image height in pixels
- THRESHOLD, 0: a pixel is bright iff its value is greater than THRESHOLD (unsigned)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; accepted only in IDLE
- mostTop  in  YW  first row to scan; sampled on accept
- mostBottom  in  YW  last row to scan, inclusive; sampled on accept
- midPix  in  XW  seed column; sampled on accept
- mem_addr  out  AW  RAM read address, registered
- mem_q  in  CW  RAM data; valid 1 cycle after mem_addr
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at completion
- found  out  1  at least one bright pixel seen; valid with done, held
- err  out  1  bad parameters on accept; valid with done, held
- mostLeft  out  XW  minimum bright column; held until next accept
- mostRight  out  XW  maximum bright column; held until next accept

## Operation
- States: IDLE, ROW_START, ADDR, CMP, NEXT_ROW, DONE.
- Accept (IDLE and start):
  - latch inputs; set y=mostTop; set mostLeft=WIDTH-1, mostRight=0, found=0, err=0.
- Bad-parameter check: mostTop>mostBottom, mostBottom>=HEIGHT, or midPix>=WIDTH.
  - Go straight to DONE with err=1 and no reads; mem_addr unchanged.
- ROW_START sets x=midPix and phase=MID.
- ADDR drives mem_addr=y*WIDTH+x (widths zero-extended, truncated to AW). CMP samples mem_q.
- Phase MID:
  - Dark: row ends, go to NEXT_ROW.
  - Bright: update extents. Then if x==WIDTH-1, go to phase LEFT; else x=x+1 and phase RIGHT.
- Phase RIGHT:
  - Bright: update extents. If x==WIDTH-1, switch to LEFT; else x=x+1.
  - Dark: switch to LEFT.
  - Switching to LEFT: if midPix==0, go to NEXT_ROW; else x=midPix-1.
- Phase LEFT:
  - Bright: update extents. If x==0, go to NEXT_ROW; else x=x-1.
  - Dark: go to NEXT_ROW.
- Update extents: found=1; mostLeft=min(mostLeft,x); mostRight=max(mostRight,x).
- The scan never wraps past column 0 or column WIDTH-1.
- NEXT_ROW: if y==mostBottom go to DONE; else y=y+1 and go to ROW_START. Row increment never wraps.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- If found=0 at DONE, mostLeft=WIDTH-1 and mostRight=0 (defined "empty" encoding).
- start while busy or in DONE is ignored and is not queued.

## Timing
- Reset values: busy=0, done=0, found=0, err=0, mostLeft=0, mostRight=0, mem_addr=0, state IDLE.
- Reset mid-scan aborts in the same edge with no done pulse.
- Each pixel read costs 2 cycles (ADDR then CMP). ROW_START and NEXT_ROW cost 1 cycle each. DONE costs 1 cycle.
- Latency from the accept edge to the done-high cycle: N = Σrows(2·reads_row + 2) + 1.
  - reads_row counts MID, RIGHT and LEFT reads, including the terminating dark read.
- Error case: done is high on the cycle after accept.
- mostLeft, mostRight and found are stable and final when done is high.

## Test plan
- 6x6 image, only (3,2) bright; top=bottom=2, mid=3.
  - Expect 3 reads (addrs 15,16,14), done at N=9, mostLeft=mostRight=3, found=1, err=0.
- Diamond: (2,1); (1..3,2); (2,3); top=1, bottom=3, mid=2.
  - Expect mostLeft=1, mostRight=3, found=1, done at N=29.
- Row 4 fully bright (x=0..5), top=bottom=4, mid=2.
  - Expect no out-of-range address (max 29, min 24), mostLeft=0, mostRight=5.
- Rows 0..1 with mid column dark in row 0, bright (4,1) and (5,1), mid=4.
  - Row 0 does 1 read. Expect mostLeft=4, mostRight=5.
- Bad parameters, top=3, bottom=1: expect done the next cycle, err=1, found=0, mem_addr unchanged.
  - Then a valid start clears err.
- Reset asserted during RIGHT phase: next cycle busy=0, done=0, outputs at reset values.
  - A second start during busy is ignored and the first result is unchanged.
